// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver path.
package uart_rx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_PAR   = 3'd3;
  localparam state_t ST_STOP  = 3'd4;
  localparam state_t ST_BRK   = 3'd5;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Clocks per oversample tick; clamped to 1 so the tick counter stays legal.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned d;
    d = clk_freq / (baud * os);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, realignable by clr.
module uart_os_tick_gen #(
  parameter int unsigned DIV = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clr || (cnt_q == LAST)) cnt_d = '0;
    else                        cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling 8N1 UART receiver with mid-bit majority vote, false-start rejection,
// optional parity and framing-error / break handling.
module uart_rx_oversample
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 1000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned PARITY     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] doutrx,
  output logic       donerx,
  output logic       perr,
  output logic       ferr,
  output logic       busy
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_A    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_VOTE = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  state_t        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d, doutrx_q, doutrx_d;
  logic          samp_a_q, samp_a_d, samp_b_q, samp_b_d;
  logic          par_err_q, par_err_d;
  logic          donerx_q, donerx_d, perr_q, perr_d, ferr_q, ferr_d, busy_q, busy_d;
  logic          fall, start_clr, tick, vote, at_vote, at_end, par_exp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall      = rx_prev_q & ~rx_sync_q;
  assign start_clr = (state_q == ST_IDLE) && fall;

  uart_os_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_clr),
    .tick (tick)
  );

  // Third sample is taken live at the vote tick; the first two were latched earlier.
  assign vote    = (samp_a_q & samp_b_q) | (samp_a_q & rx_sync_q) | (samp_b_q & rx_sync_q);
  assign at_vote = tick && (s_q == S_VOTE);
  assign at_end  = tick && (s_q == S_LAST);
  assign par_exp = (PARITY == PAR_ODD) ? ~(^shift_q) : (^shift_q);

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    samp_a_d  = samp_a_q;
    samp_b_d  = samp_b_q;
    par_err_d = par_err_q;
    doutrx_d  = doutrx_q;
    donerx_d  = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    if (start_clr)  s_d = '0;
    else if (tick)  s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
    if (tick && (s_q == S_A)) samp_a_d = rx_sync_q;
    if (tick && (s_q == S_B)) samp_b_d = rx_sync_q;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d   = ST_START;
          bit_d     = '0;
          par_err_d = 1'b0;
        end
      end
      ST_START: begin
        if (at_vote && vote) state_d = ST_IDLE;
        else if (at_end)     state_d = ST_DATA;
      end
      ST_DATA: begin
        if (at_vote) shift_d = {vote, shift_q[7:1]};
        if (at_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
        end
      end
      ST_PAR: begin
        if (at_vote) par_err_d = (vote != par_exp);
        if (at_end)  state_d = ST_STOP;
      end
      ST_STOP: begin
        // Decide at the stop vote so a new start edge can be caught mid stop bit.
        if (at_vote) begin
          if (vote) begin
            doutrx_d = shift_q;
            donerx_d = 1'b1;
            perr_d   = par_err_q;
            state_d  = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BRK;
          end
        end
      end
      ST_BRK: begin
        if (rx_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_q != ST_IDLE) || (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      samp_a_q  <= 1'b0;
      samp_b_q  <= 1'b0;
      par_err_q <= 1'b0;
      doutrx_q  <= '0;
      donerx_q  <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      samp_a_q  <= samp_a_d;
      samp_b_q  <= samp_b_d;
      par_err_q <= par_err_d;
      doutrx_q  <= doutrx_d;
      donerx_q  <= donerx_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign doutrx = doutrx_q;
  assign donerx = donerx_q;
  assign perr   = perr_q;
  assign ferr   = ferr_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: scoreboard of expected bytes checked on donerx.
module tb_uart_rx_oversample;

  localparam int BIT = 104;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [7:0] doutrx0, doutrx1;
  logic       donerx0, donerx1, perr0, perr1, ferr0, ferr1, busy0, busy1;

  int n_vec = 0;
  int n_err = 0;
  int ferr_cnt0 = 0;
  int ferr_cnt1 = 0;
  int done_cnt0 = 0;
  logic chk_busy0 = 1'b0;
  logic chk_busy1 = 1'b0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] last_byte0 = 8'h00;

  always #5 clk = ~clk;

  uart_rx_oversample #(
    .CLK_FREQ   (1000000),
    .BAUD       (9600),
    .OVERSAMPLE (8),
    .PARITY     (0)
  ) dut0 (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx0),
    .doutrx (doutrx0),
    .donerx (donerx0),
    .perr   (perr0),
    .ferr   (ferr0),
    .busy   (busy0)
  );

  uart_rx_oversample #(
    .CLK_FREQ   (1000000),
    .BAUD       (9600),
    .OVERSAMPLE (8),
    .PARITY     (1)
  ) dut1 (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx1),
    .doutrx (doutrx1),
    .donerx (donerx1),
    .perr   (perr1),
    .ferr   (ferr1),
    .busy   (busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input int which, input logic b);
    if (which == 0) rx0 = b;
    else            rx1 = b;
    repeat (BIT) @(negedge clk);
  endtask

  // par_bit < 0 means no parity bit; dut1 uses even parity.
  task automatic send_frame(input int which, input logic [7:0] d, input logic stop_bit,
                            input int par_bit);
    logic pe;
    pe = (par_bit >= 0) ? ((^d) != par_bit[0]) : 1'b0;
    if (stop_bit) begin
      if (which == 0) begin
        q0.push_back({pe, d});
        last_byte0 = d;
      end else begin
        q1.push_back({pe, d});
      end
    end
    @(negedge clk);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (par_bit >= 0) drive_bit(which, par_bit[0]);
    drive_bit(which, stop_bit);
  endtask

  task automatic drain(input int which);
    int n;
    n = 0;
    while ((((which == 0) ? q0.size() : q1.size()) != 0) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain%0d", which), 32'((which == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (chk_busy0) check("busy_after_done0", 32'(busy0), 32'd0);
    chk_busy0 = 1'b0;
    if (ferr0) ferr_cnt0++;
    if (donerx0 || ferr0) check("done_ferr_excl0", 32'(donerx0 & ferr0), 32'd0);
    if (donerx0) begin
      done_cnt0++;
      check("done_expected0", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("doutrx0", 32'(doutrx0), 32'(e[7:0]));
        check("perr0", 32'(perr0), 32'(e[8]));
        check("busy_at_done0", 32'(busy0), 32'd1);
        chk_busy0 = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (chk_busy1) check("busy_after_done1", 32'(busy1), 32'd0);
    chk_busy1 = 1'b0;
    if (ferr1) ferr_cnt1++;
    if (donerx1) begin
      check("done_expected1", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("doutrx1", 32'(doutrx1), 32'(e[7:0]));
        check("perr1", 32'(perr1), 32'(e[8]));
        chk_busy1 = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc, dc, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_doutrx0", 32'(doutrx0), 32'h00);
    check("rst_flags0", 32'({donerx0, perr0, ferr0, busy0}), 32'd0);
    check("rst_doutrx1", 32'(doutrx1), 32'h00);
    check("rst_flags1", 32'({donerx1, perr1, ferr1, busy1}), 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // Single frame
    send_frame(0, 8'hA5, 1'b1, -1);
    drain(0);
    repeat (20) @(negedge clk);

    // Back-to-back frames
    send_frame(0, 8'h00, 1'b1, -1);
    send_frame(0, 8'hFF, 1'b1, -1);
    send_frame(0, 8'h3C, 1'b1, -1);
    drain(0);
    repeat (200) @(negedge clk);

    // False start
    fc = ferr_cnt0;
    dc = done_cnt0;
    rx0 = 1'b0;
    repeat (30) @(negedge clk);
    rx0 = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("false_start_busy", 32'(busy0), 32'd0);
    check("false_start_done", 32'(done_cnt0), 32'(dc));
    check("false_start_ferr", 32'(ferr_cnt0), 32'(fc));
    check("false_start_hold", 32'(doutrx0), 32'(last_byte0));

    // Framing error then break
    fc = ferr_cnt0;
    dc = done_cnt0;
    send_frame(0, 8'h55, 1'b0, -1);
    repeat (500) @(negedge clk);
    check("brk_ferr_once", 32'(ferr_cnt0), 32'(fc + 1));
    check("brk_no_done", 32'(done_cnt0), 32'(dc));
    check("brk_busy", 32'(busy0), 32'd1);
    check("brk_hold", 32'(doutrx0), 32'(last_byte0));
    rx0 = 1'b1;
    n = 0;
    while (busy0 && (n < 10)) begin
      @(negedge clk);
      n++;
    end
    check("brk_release_busy", 32'(busy0), 32'd0);
    repeat (20) @(negedge clk);
    send_frame(0, 8'h12, 1'b1, -1);
    drain(0);
    check("ferr_total", 32'(ferr_cnt0), 32'(fc + 1));
    repeat (20) @(negedge clk);

    // Even parity: correct then wrong parity bit
    send_frame(1, 8'h07, 1'b1, 1);
    repeat (20) @(negedge clk);
    send_frame(1, 8'h07, 1'b1, 0);
    drain(1);
    check("par_no_ferr", 32'(ferr_cnt1), 32'd0);
    repeat (20) @(negedge clk);

    // Reset mid-frame during data bit 4 of 8'hC3
    @(negedge clk);
    rx0 = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(0, n_vec >= 0 ? 1'(8'hC3 >> i) : 1'b0);
    rx0 = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_doutrx", 32'(doutrx0), 32'h00);
    check("midrst_flags", 32'({donerx0, perr0, ferr0, busy0}), 32'd0);
    rx0 = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("postrst_idle", 32'(busy0), 32'd0);
    send_frame(0, 8'h81, 1'b1, -1);
    drain(0);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
